// File: rtl/icache_dataram_arb_if.sv
// Bundle of the requester, RAM and response signals for the icache data RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface icache_dataram_arb_if #(
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 1,
    parameter int DATA_WIDTH  = 512,
    parameter int TXNID_WIDTH = 5
);
    localparam int ADDR_WIDTH = INDEX_WIDTH + WAY_WIDTH;

    // hit-read request
    logic                   rd_vld;
    logic                   rd_rdy;
    logic [INDEX_WIDTH-1:0] rd_index;
    logic [WAY_WIDTH-1:0]   rd_way;
    logic [TXNID_WIDTH-1:0] rd_txnid;

    // linefill write request
    logic                   wr_vld;
    logic                   wr_rdy;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [WAY_WIDTH-1:0]   wr_way;
    logic [DATA_WIDTH-1:0]  wr_data;

    // single-port data RAM
    logic                   ram_en;
    logic                   ram_wr_en;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    // read responses
    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic [TXNID_WIDTH-1:0] rsp_txnid;

    modport slave (
        input  rd_vld, rd_index, rd_way, rd_txnid,
        input  wr_vld, wr_index, wr_way, wr_data,
        input  ram_rdata, rsp_rdy,
        output rd_rdy, wr_rdy,
        output ram_en, ram_wr_en, ram_addr, ram_wdata,
        output rsp_vld, rsp_data, rsp_txnid
    );

    modport master (
        output rd_vld, rd_index, rd_way, rd_txnid,
        output wr_vld, wr_index, wr_way, wr_data,
        output ram_rdata, rsp_rdy,
        input  rd_rdy, wr_rdy,
        input  ram_en, ram_wr_en, ram_addr, ram_wdata,
        input  rsp_vld, rsp_data, rsp_txnid
    );
endinterface

// File: rtl/icache_dataram_arb.sv
// Arbiter for the single-port icache data RAM: linefill writes win by default,
// a starvation counter eventually forces a hit read through, and read data is
// captured one cycle after the RAM read into an in-order, credit-protected FIFO.
module icache_dataram_arb #(
    parameter int INDEX_WIDTH  = 6,
    parameter int WAY_WIDTH    = 1,
    parameter int DATA_WIDTH   = 512,
    parameter int TXNID_WIDTH  = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int RSP_DEPTH    = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    icache_dataram_arb_if.slave  bus
);
    localparam int ADDR_WIDTH = INDEX_WIDTH + WAY_WIDTH;
    localparam int PTR_WIDTH  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_WIDTH  = $clog2(RSP_DEPTH + 1);
    localparam int SC_WIDTH   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        WR_FIRST = 1'b0,
        RD_FIRST = 1'b1
    } mode_t;

    mode_t                  mode_q, mode_d;
    logic [SC_WIDTH-1:0]    starve_q, starve_d;
    logic                   rd_pend_q;
    logic [TXNID_WIDTH-1:0] txnid_q;

    logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]   fifo_cnt_q;
    logic [DATA_WIDTH-1:0]  mem_data  [RSP_DEPTH];
    logic [TXNID_WIDTH-1:0] mem_txnid [RSP_DEPTH];

    logic                   rd_rdy_c, wr_rdy_c;
    logic                   rd_grant, wr_grant;
    logic                   push, pop, fifo_vld;
    logic [CNT_WIDTH:0]     occupancy;
    logic                   cr_ok;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(RSP_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Credit: a read may only be granted if its response is guaranteed a FIFO slot,
    // counting the read already in the RAM pipeline and a pop happening this cycle.
    assign fifo_vld  = (fifo_cnt_q != '0);
    assign pop       = fifo_vld && bus.rsp_rdy;
    assign push      = rd_pend_q;
    assign occupancy = {1'b0, fifo_cnt_q} + (CNT_WIDTH+1)'(rd_pend_q) - (CNT_WIDTH+1)'(pop);
    assign cr_ok     = (occupancy < (CNT_WIDTH+1)'(RSP_DEPTH));

    // Grant selection and mode/starvation next-state.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        rd_rdy_c = 1'b0;
        wr_rdy_c = 1'b0;
        mode_d   = mode_q;
        starve_d = starve_q;
        unique case (mode_q)
            WR_FIRST: begin
                rd_rdy_c = cr_ok && !bus.wr_vld;
                wr_rdy_c = 1'b1;
                if (bus.rd_vld && cr_ok && bus.wr_vld) begin
                    if (starve_q == SC_WIDTH'(STARVE_LIMIT - 1)) begin
                        mode_d   = RD_FIRST;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + SC_WIDTH'(1);
                    end
                end else if (bus.rd_vld && rd_rdy_c) begin
                    starve_d = '0;
                end
            end
            RD_FIRST: begin
                rd_rdy_c = cr_ok;
                wr_rdy_c = !(bus.rd_vld && cr_ok);
                starve_d = '0;
                if (!bus.rd_vld || cr_ok) begin
                    mode_d = WR_FIRST;
                end
            end
            default: begin
                mode_d   = WR_FIRST;
                starve_d = '0;
            end
        endcase
        if (!rst_n) begin
            rd_rdy_c = 1'b0;
            wr_rdy_c = 1'b0;
        end
    end

    assign bus.rd_rdy = rd_rdy_c;
    assign bus.wr_rdy = wr_rdy_c;
    assign rd_grant   = bus.rd_vld && rd_rdy_c;
    assign wr_grant   = bus.wr_vld && wr_rdy_c;

    // RAM drive for the granted requester; address and write data idle at zero.
    always_comb begin
        bus.ram_en    = rd_grant || wr_grant;
        bus.ram_wr_en = wr_grant;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (wr_grant) begin
            bus.ram_addr  = {bus.wr_index, bus.wr_way};
            bus.ram_wdata = bus.wr_data;
        end else if (rd_grant) begin
            bus.ram_addr = {bus.rd_index, bus.rd_way};
        end
    end

    // Mode, starvation counter and the one-deep read pipeline stage.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= WR_FIRST;
            starve_q  <= '0;
            rd_pend_q <= 1'b0;
            txnid_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            starve_q  <= starve_d;
            rd_pend_q <= rd_grant;
            if (rd_grant) begin
                txnid_q <= bus.rd_txnid;
            end
        end
    end

    // Response FIFO pointers and occupancy; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_WIDTH'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_WIDTH'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Response FIFO storage, written with the RAM data one cycle after the read grant.
    // NOTE: storage is not reset; entries are only observed through the valid-gated head below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q]  <= bus.ram_rdata;
            mem_txnid[wr_ptr_q] <= txnid_q;
        end
    end

    assign bus.rsp_vld   = fifo_vld;
    assign bus.rsp_data  = fifo_vld ? mem_data[rd_ptr_q]  : '0;
    assign bus.rsp_txnid = fifo_vld ? mem_txnid[rd_ptr_q] : '0;

endmodule

// File: tb/tb_icache_dataram_arb.sv
// Directed bench for icache_dataram_arb: a behavioural 1-cycle RAM, one task per scenario.
module tb_icache_dataram_arb;
    localparam int IW = 6;
    localparam int WW = 1;
    localparam int DW = 512;
    localparam int TW = 5;
    localparam int STARVE_LIMIT = 4;
    localparam int RSP_DEPTH = 2;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    icache_dataram_arb_if #(.INDEX_WIDTH(IW), .WAY_WIDTH(WW), .DATA_WIDTH(DW), .TXNID_WIDTH(TW)) bus ();

    icache_dataram_arb #(
        .INDEX_WIDTH(IW), .WAY_WIDTH(WW), .DATA_WIDTH(DW), .TXNID_WIDTH(TW),
        .STARVE_LIMIT(STARVE_LIMIT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: unwritten lines read back a pattern derived from their address.
    function automatic logic [DW-1:0] line_init(input logic [IW+WW-1:0] a);
        return {16{32'hD000_0000 | {25'd0, a}}};
    endfunction

    logic [DW-1:0] ram_mem     [0:127];
    bit            ram_written [0:127];

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_wr_en) begin
                ram_mem[bus.ram_addr]     <= bus.ram_wdata;
                ram_written[bus.ram_addr] <= 1'b1;
            end else begin
                bus.ram_rdata <= ram_written[bus.ram_addr] ? ram_mem[bus.ram_addr] : line_init(bus.ram_addr);
            end
        end
    end

    // Reads accepted but not yet popped must never exceed the FIFO depth.
    int occ;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else occ <= occ + ((bus.rd_vld && bus.rd_rdy) ? 1 : 0) - ((bus.rsp_vld && bus.rsp_rdy) ? 1 : 0);
    end
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (occ > RSP_DEPTH) begin fails++; $display("FAIL overflow: outstanding %0d, limit %0d", occ, RSP_DEPTH); end
        end
    end

    task automatic clear_inputs();
        bus.rd_vld = 1'b0; bus.rd_index = '0; bus.rd_way = '0; bus.rd_txnid = '0;
        bus.wr_vld = 1'b0; bus.wr_index = '0; bus.wr_way = '0; bus.wr_data = '0;
        bus.rsp_rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rd_vld = 1'b1; bus.wr_vld = 1'b1; bus.rsp_rdy = 1'b1;
        #1;
        tests++; if (bus.rd_rdy !== 1'b0)    begin fails++; $display("FAIL rst_rd_rdy: got %b want 0", bus.rd_rdy); end
        tests++; if (bus.wr_rdy !== 1'b0)    begin fails++; $display("FAIL rst_wr_rdy: got %b want 0", bus.wr_rdy); end
        tests++; if (bus.ram_en !== 1'b0)    begin fails++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
        tests++; if (bus.ram_wr_en !== 1'b0) begin fails++; $display("FAIL rst_ram_wr_en: got %b want 0", bus.ram_wr_en); end
        tests++; if (bus.rsp_vld !== 1'b0)   begin fails++; $display("FAIL rst_rsp_vld: got %b want 0", bus.rsp_vld); end
        tests++; if (bus.rsp_data !== '0)    begin fails++; $display("FAIL rst_rsp_data: got %0h want 0", bus.rsp_data); end
        tests++; if (bus.rsp_txnid !== '0)   begin fails++; $display("FAIL rst_rsp_txnid: got %0h want 0", bus.rsp_txnid); end
        do_reset();
    endtask

    task automatic test_lone_read();
        logic [DW-1:0] exp_d;
        exp_d = {16{32'hD000_000B}};
        do_reset();
        @(negedge clk);
        bus.rd_vld = 1'b1; bus.rd_index = 6'd5; bus.rd_way = 1'b1; bus.rd_txnid = 5'd3;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1)    begin fails++; $display("FAIL t1_rd_rdy: got %b want 1", bus.rd_rdy); end
        tests++; if (bus.ram_en !== 1'b1)    begin fails++; $display("FAIL t1_ram_en: got %b want 1", bus.ram_en); end
        tests++; if (bus.ram_wr_en !== 1'b0) begin fails++; $display("FAIL t1_ram_wr_en: got %b want 0", bus.ram_wr_en); end
        tests++; if (bus.ram_addr !== 7'h0B) begin fails++; $display("FAIL t1_ram_addr: got %0h want 0b", bus.ram_addr); end
        @(negedge clk);
        bus.rd_vld = 1'b0;
        #1;
        tests++; if (bus.rsp_vld !== 1'b0)   begin fails++; $display("FAIL t1_early_rsp: got %b want 0", bus.rsp_vld); end
        @(negedge clk);
        #1;
        tests++; if (bus.rsp_vld !== 1'b1)   begin fails++; $display("FAIL t1_rsp_vld: got %b want 1", bus.rsp_vld); end
        tests++; if (bus.rsp_data !== exp_d) begin fails++; $display("FAIL t1_rsp_data: got %0h want %0h", bus.rsp_data, exp_d); end
        tests++; if (bus.rsp_txnid !== 5'd3) begin fails++; $display("FAIL t1_rsp_txnid: got %0d want 3", bus.rsp_txnid); end
        @(negedge clk);
        #1;
        tests++; if (bus.rsp_vld !== 1'b0)   begin fails++; $display("FAIL t1_popped: got %b want 0", bus.rsp_vld); end
    endtask

    task automatic test_starvation();
        do_reset();
        @(negedge clk);
        bus.wr_vld = 1'b1; bus.wr_index = 6'd9; bus.wr_way = 1'b0; bus.wr_data = {16{32'h1234_5678}};
        bus.rd_vld = 1'b1; bus.rd_index = 6'd1; bus.rd_way = 1'b0; bus.rd_txnid = 5'd5;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests++; if (bus.rd_rdy !== (c == 4)) begin fails++; $display("FAIL t2_rd_rdy cycle %0d: got %b want %b", c, bus.rd_rdy, (c == 4)); end
            tests++; if (bus.wr_rdy !== (c != 4)) begin fails++; $display("FAIL t2_wr_rdy cycle %0d: got %b want %b", c, bus.wr_rdy, (c != 4)); end
        end
        @(negedge clk);
        bus.rd_vld = 1'b0; bus.wr_vld = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_credit_stall();
        do_reset();
        @(negedge clk);
        bus.rsp_rdy = 1'b0; bus.rd_vld = 1'b1; bus.rd_txnid = 5'd10;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1) begin fails++; $display("FAIL t3_grant_a: got %b want 1", bus.rd_rdy); end
        @(negedge clk);
        bus.rd_txnid = 5'd11;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1) begin fails++; $display("FAIL t3_grant_b: got %b want 1", bus.rd_rdy); end
        @(negedge clk);
        bus.rd_txnid = 5'd12;
        #1;
        tests++; if (bus.rd_rdy !== 1'b0) begin fails++; $display("FAIL t3_stall_c: got %b want 0", bus.rd_rdy); end
        repeat (2) @(negedge clk);
        #1;
        tests++; if (bus.rd_rdy !== 1'b0)     begin fails++; $display("FAIL t3_still_stalled: got %b want 0", bus.rd_rdy); end
        tests++; if (bus.rsp_txnid !== 5'd10) begin fails++; $display("FAIL t3_head_a: got %0d want 10", bus.rsp_txnid); end
        @(negedge clk);
        bus.rsp_rdy = 1'b1;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1) begin fails++; $display("FAIL t3_grant_c_on_pop: got %b want 1", bus.rd_rdy); end
        @(negedge clk);
        bus.rd_vld = 1'b0;
        #1;
        tests++; if (bus.rsp_txnid !== 5'd11) begin fails++; $display("FAIL t3_head_b: got %0d want 11", bus.rsp_txnid); end
        @(negedge clk);
        #1;
        tests++; if (bus.rsp_txnid !== 5'd12) begin fails++; $display("FAIL t3_head_c: got %0d want 12", bus.rsp_txnid); end
        @(negedge clk);
        #1;
        tests++; if (bus.rsp_vld !== 1'b0) begin fails++; $display("FAIL t3_drained: got %b want 0", bus.rsp_vld); end
    endtask

    task automatic test_write_then_read();
        logic [DW-1:0] pat;
        pat = {16{32'hA5A5_0001}};
        do_reset();
        @(negedge clk);
        bus.wr_vld = 1'b1; bus.wr_index = 6'd2; bus.wr_way = 1'b0; bus.wr_data = pat;
        #1;
        tests++; if (bus.wr_rdy !== 1'b1)    begin fails++; $display("FAIL t4_wr_rdy: got %b want 1", bus.wr_rdy); end
        tests++; if (bus.ram_wr_en !== 1'b1) begin fails++; $display("FAIL t4_ram_wr_en: got %b want 1", bus.ram_wr_en); end
        tests++; if (bus.ram_addr !== 7'h04) begin fails++; $display("FAIL t4_ram_addr: got %0h want 04", bus.ram_addr); end
        tests++; if (bus.ram_wdata !== pat)  begin fails++; $display("FAIL t4_ram_wdata: got %0h want %0h", bus.ram_wdata, pat); end
        @(negedge clk);
        bus.wr_vld = 1'b0;
        bus.rd_vld = 1'b1; bus.rd_index = 6'd2; bus.rd_way = 1'b0; bus.rd_txnid = 5'd7;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1)    begin fails++; $display("FAIL t4_rd_rdy: got %b want 1", bus.rd_rdy); end
        tests++; if (bus.ram_wdata !== '0)   begin fails++; $display("FAIL t4_wdata_idle: got %0h want 0", bus.ram_wdata); end
        @(negedge clk);
        bus.rd_vld = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (bus.rsp_vld !== 1'b1)   begin fails++; $display("FAIL t4_rsp_vld: got %b want 1", bus.rsp_vld); end
        tests++; if (bus.rsp_data !== pat)   begin fails++; $display("FAIL t4_rsp_data: got %0h want %0h", bus.rsp_data, pat); end
        tests++; if (bus.rsp_txnid !== 5'd7) begin fails++; $display("FAIL t4_rsp_txnid: got %0d want 7", bus.rsp_txnid); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent;
        logic [TW-1:0] got [$];
        sent = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.rsp_rdy  = (c % 2 == 0);
            bus.rd_vld   = (sent < 3);
            bus.rd_txnid = TW'(sent + 1);
            #1;
            if (bus.rd_vld && bus.rd_rdy) sent++;
            if (bus.rsp_vld && bus.rsp_rdy) got.push_back(bus.rsp_txnid);
        end
        bus.rd_vld = 1'b0;
        tests++; if (sent !== 3)       begin fails++; $display("FAIL t5_sent: got %0d want 3", sent); end
        tests++; if (got.size() !== 3) begin fails++; $display("FAIL t5_rsp_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests++; if (got[i] !== TW'(i + 1)) begin fails++; $display("FAIL t5_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        bus.rd_vld = 1'b1; bus.rd_index = 6'd3; bus.rd_txnid = 5'd9; bus.rsp_rdy = 1'b1;
        #1;
        tests++; if (bus.rd_rdy !== 1'b1) begin fails++; $display("FAIL t6_grant: got %b want 1", bus.rd_rdy); end
        @(negedge clk);
        rst_n = 1'b0; bus.wr_vld = 1'b1;
        #1;
        tests++; if (bus.rd_rdy !== 1'b0) begin fails++; $display("FAIL t6_rd_rdy_in_rst: got %b want 0", bus.rd_rdy); end
        tests++; if (bus.wr_rdy !== 1'b0) begin fails++; $display("FAIL t6_wr_rdy_in_rst: got %b want 0", bus.wr_rdy); end
        tests++; if (bus.ram_en !== 1'b0) begin fails++; $display("FAIL t6_ram_en_in_rst: got %b want 0", bus.ram_en); end
        @(negedge clk);
        rst_n = 1'b1; bus.rd_vld = 1'b0; bus.wr_vld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            tests++; if (bus.rsp_vld !== 1'b0) begin fails++; $display("FAIL t6_ghost_rsp cycle %0d: got txnid %0d, want no response", c, bus.rsp_txnid); end
        end
        @(negedge clk);
        bus.rd_vld = 1'b1; bus.wr_vld = 1'b1;
        #1;
        tests++; if (bus.rd_rdy !== 1'b0) begin fails++; $display("FAIL t6_mode_rd_rdy: got %b want 0", bus.rd_rdy); end
        tests++; if (bus.wr_rdy !== 1'b1) begin fails++; $display("FAIL t6_mode_wr_rdy: got %b want 1", bus.wr_rdy); end
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_lone_read();
        test_starvation();
        test_credit_stall();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
